instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage sitting directly upstream of the single-cycle datapath: it turns the datapath's `pc` into the `instruction` word the datapath decodes. It fetches from a variable-latency instruction memory over a req/ack handshake, holds the last fetched word in a one-entry tagged buffer, and raises `stall` while a fetch is outstanding; the integrator gates the PC register enable and register-file `writeEnable` with `!stall`. Misaligned PCs and memory timeouts yield a NOP plus a one-cycle `fetchErr` pulse instead of hanging the core.

## Interface
- `n`, 32, instruction and PC width
- `timeout`, 15, FETCH cycles allowed before abandoning a request (1..255)
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; one clock, asynchronous active-low reset
- `pc`  in  n  current PC from datapath; stable while `stall`=1
- `memReq`  out  1  request to instruction memory
- `memAddr`  out  n-5  word address = `pc[n-1:5]`, registered
- `memAck`  in  1  memory has valid `memData` this cycle
- `memData`  in  n  fetched word, sampled only when `memReq` & `memAck`
- `instruction`  out  n  word for datapath (registered)
- `instrValid`  out  1  `instruction` corresponds to current `pc`
- `stall`  out  1  datapath must hold PC and suppress writes
- `fetchErr`  out  1  one-cycle pulse: misaligned PC or timeout

## Operation
- State: `bufValid`, `tag[n-1:0]`, `instruction`, FSM {IDLE, FETCH}, timeout counter `cnt` (8 bits).
- hit = `bufValid` & (`tag` == `pc`) & state==IDLE. `instrValid` = hit; `stall` = !hit (combinational).
- IDLE, hit: nothing changes.
- IDLE, miss, `pc[4:0]`!=0 (misaligned): no request; `instruction`<=NOP, `tag`<=`pc`, `bufValid`<=1, `fetchErr`<=1; stay IDLE.
- IDLE, miss, aligned: `memReq`<=1, `memAddr`<=`pc[n-1:5]`, `cnt`<=0, go FETCH.
- FETCH: `memReq`, `memAddr` held stable until exit. Each cycle without ack, `cnt`++.
  - `memAck`=1: `instruction`<=`memData`, `tag`<=`pc`, `bufValid`<=1, `memReq`<=0, go IDLE.
  - `cnt`==`timeout`-1 and no ack: `instruction`<=NOP, `tag`<=`pc`, `bufValid`<=1, `memReq`<=0, `fetchErr`<=1, go IDLE.
  - Ack and timeout in same cycle: ack wins, no `fetchErr`.
- `memAck` while `memReq`=0 is ignored (covers late acks after timeout/reset).
- `fetchErr` is a registered pulse, cleared the cycle after it is set.
- NOP = all zeros.

## Timing
- Reset (asserted): state IDLE, `bufValid`=0, `tag`=0, `instruction`=0, `memReq`=0, `memAddr`=0, `fetchErr`=0, `cnt`=0; hence `instrValid`=0, `stall`=1.
- Miss latency: new `pc` at cycle 0 → `memReq` high cycle 1 → ack at cycle k≥1 → `instrValid`=1, `stall`=0 at cycle k+1. Minimum 2 cycles.
- Misaligned: `stall` for exactly 1 cycle; NOP valid and `fetchErr`=1 at cycle 1.
- Timeout: `memReq` high cycles 1..`timeout`; NOP valid and `fetchErr` at cycle `timeout`+1.
- Hit: zero latency, `stall`=0 combinationally.
- Reset mid-FETCH: `memReq` drops asynchronously; buffer invalidated; next fetch restarts after release.
- `pc` changing during FETCH is a protocol violation; captured `tag` is `pc` at ack time (unchecked).

## Structure
- Package `fetch_pkg`: `NOP` constant, `WORD_SHIFT`=5, FSM state enum `fetch_state_t` {IDLE, FETCH}.
- Sub-module `fetch_timer`: loadable 8-bit counter with `clear`, `en`, `expired` (= count==`timeout`-1); everything else inline. Existing `dff` may hold `tag`/`instruction`.

## Test plan
- Reset release, `pc`=0, memory acks after 3 cycles with 32'hDEAD0001 → `memReq` cycles 1–3, `memAddr`=0, `instruction`=32'hDEAD0001, `stall`=0 at cycle 4.
- `pc` held at 0 after fill, then `pc`=32 with ack in 1 cycle → no stall while at 0; `memAddr`=1, valid 2 cycles after change.
- `pc`=32'h0000_0021 → no `memReq`; `instruction`=0, `fetchErr` pulse, 1-cycle stall.
- `pc`=64, memory never acks, `timeout`=15 → `memReq` high exactly 15 cycles, then NOP, one `fetchErr` pulse; late ack next cycle ignored (`instruction` stays 0).
- Ack arriving on final timeout cycle with 32'h1234_5678 → loaded, no `fetchErr`.
- Assert `reset` during FETCH (cycle 2 of wait) → `memReq`=0 immediately, `instrValid`=0; after release, same `pc` re-fetched from scratch.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned WORD_SHIFT = 5;
  localparam int unsigned CNT_W      = 8;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Loadable 8-bit wait counter; flags the last cycle allowed for an outstanding fetch.
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int unsigned timeout = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear takes priority so a new request always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CNT_W'(timeout - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch with a one-entry tagged buffer over a req/ack memory port;
// misaligned PCs and timeouts return a NOP with a one-cycle error pulse.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned n       = 32,
  parameter int unsigned timeout = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [n-1:0]           pc,
  output logic                   memReq,
  output logic [n-WORD_SHIFT-1:0] memAddr,
  input  logic                   memAck,
  input  logic [n-1:0]           memData,
  output logic [n-1:0]           instruction,
  output logic                   instrValid,
  output logic                   stall,
  output logic                   fetchErr
);

  localparam int unsigned AW = n - WORD_SHIFT;

  fetch_state_t  state_q, state_d;
  logic          buf_valid_q, buf_valid_d;
  logic [n-1:0]  tag_q, tag_d;
  logic [n-1:0]  instr_q, instr_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          fetch_err_q, fetch_err_d;

  logic          hit;
  logic          timer_clear;
  logic          timer_en;
  logic          timer_expired;

  fetch_timer #(
    .timeout (timeout)
  ) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (timer_clear),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // The buffered word only counts while no fetch is in flight.
  assign hit        = buf_valid_q && (tag_q == pc) && (state_q == IDLE);
  assign instrValid = hit;
  assign stall      = !hit;

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    tag_d       = tag_q;
    instr_d     = instr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fetch_err_d = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!hit) begin
          if (pc[WORD_SHIFT-1:0] != '0) begin
            instr_d     = n'(NOP);
            tag_d       = pc;
            buf_valid_d = 1'b1;
            fetch_err_d = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = pc[n-1:WORD_SHIFT];
            timer_clear = 1'b1;
            state_d     = FETCH;
          end
        end
      end

      FETCH: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_req_q && memAck) begin
          instr_d     = memData;
          tag_d       = pc;
          buf_valid_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end else if (timer_expired) begin
          instr_d     = n'(NOP);
          tag_d       = pc;
          buf_valid_d = 1'b1;
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      tag_q       <= '0;
      instr_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      tag_q       <= tag_d;
      instr_q     <= instr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign memReq      = mem_req_q;
  assign memAddr     = mem_addr_q;
  assign instruction = instr_q;
  assign fetchErr    = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a transaction-level latency/result model.
module tb_instr_fetch;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        memReq;
  logic [26:0] memAddr;
  logic        memAck = 1'b0;
  logic [31:0] memData;
  logic [31:0] instruction;
  logic        instrValid;
  logic        stall;
  logic        fetchErr;

  int n_checks = 0;
  int n_fail   = 0;

  int   mem_delay  = 0;
  logic late_ack   = 1'b0;
  int   req_cycles = 0;

  instr_fetch #(
    .n       (32),
    .timeout (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .memReq      (memReq),
    .memAddr     (memAddr),
    .memAck      (memAck),
    .memData     (memData),
    .instruction (instruction),
    .instrValid  (instrValid),
    .stall       (stall),
    .fetchErr    (fetchErr)
  );

  always #5 clk = ~clk;

  // Memory model: acks on the mem_delay-th cycle of a request (0 = never).
  always @(posedge clk) begin
    #1;
    if (memReq) begin
      req_cycles = req_cycles + 1;
      memAck = (mem_delay != 0) && (req_cycles == mem_delay);
    end else begin
      req_cycles = 0;
      memAck = late_ack;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    int          n_req;
    int          n_err;

    reset   = 1'b0;
    pc      = 32'h0;
    memData = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memAddr", 32'(memAddr), 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_err", 32'(fetchErr), 32'd0);

    // Cold fill of pc=0, ack on the third request cycle
    mem_delay = 3;
    memData   = 32'hDEAD_0001;
    reset     = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c <= 3) begin
        chk($sformatf("fill_req_c%0d", c), 32'(memReq), 32'd1);
        chk($sformatf("fill_addr_c%0d", c), 32'(memAddr), 32'd0);
      end
    end
    chk("fill_instr", instruction, 32'hDEAD_0001);
    chk("fill_stall", 32'(stall), 32'd0);
    chk("fill_memReq_off", 32'(memReq), 32'd0);

    // Hit while pc held, then a one-cycle-ack miss at pc=32
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_stall", 32'(stall), 32'd0);
    end
    mem_delay = 1;
    memData   = 32'hA5A5_0032;
    pc        = 32'd32;
    #1;
    chk("pc32_c0_stall", 32'(stall), 32'd1);
    step();
    chk("pc32_c1_req", 32'(memReq), 32'd1);
    chk("pc32_c1_addr", 32'(memAddr), 32'd1);
    step();
    chk("pc32_c2_valid", 32'(instrValid), 32'd1);
    chk("pc32_c2_instr", instruction, 32'hA5A5_0032);
    step();

    // Timeout at pc=64 with a late ack that must be ignored
    mem_delay = 0;
    memData   = 32'hCAFE_F00D;
    pc        = 32'd64;
    n_req     = 0;
    n_err     = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (memReq) n_req++;
      if (fetchErr) n_err++;
      if (c == 1) chk("tmo_addr", 32'(memAddr), 32'd2);
      if (c == 16) begin
        chk("tmo_instr", instruction, 32'd0);
        chk("tmo_err", 32'(fetchErr), 32'd1);
        chk("tmo_valid", 32'(instrValid), 32'd1);
        late_ack = 1'b0;
      end
      if (c == 15) late_ack = 1'b1;
      if (c == 17) chk("tmo_late_ack_ignored", instruction, 32'd0);
    end
    chk("tmo_req_cycles", 32'(n_req), 32'd15);
    chk("tmo_err_pulses", 32'(n_err), 32'd1);

    // Ack on the final allowed cycle
    mem_delay = 15;
    memData   = 32'h1234_5678;
    pc        = 32'd96;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 15) chk("last_req", 32'(memReq), 32'd1);
    end
    chk("last_instr", instruction, 32'h1234_5678);
    chk("last_err", 32'(fetchErr), 32'd0);
    chk("last_valid", 32'(instrValid), 32'd1);
    step();

    // Misaligned pc
    pc = 32'h0000_0021;
    #1;
    chk("mis_c0_stall", 32'(stall), 32'd1);
    step();
    chk("mis_c1_instr", instruction, 32'd0);
    chk("mis_c1_err", 32'(fetchErr), 32'd1);
    chk("mis_c1_stall", 32'(stall), 32'd0);
    chk("mis_c1_req", 32'(memReq), 32'd0);
    step();
    chk("mis_c2_err", 32'(fetchErr), 32'd0);

    // Reset in the middle of a fetch
    mem_delay = 0;
    pc        = 32'd128;
    step();
    step();
    chk("rmf_req_before", 32'(memReq), 32'd1);
    reset = 1'b0;
    #1;
    chk("rmf_req_dropped", 32'(memReq), 32'd0);
    chk("rmf_valid", 32'(instrValid), 32'd0);
    chk("rmf_stall", 32'(stall), 32'd1);
    step();
    step();
    d0        = $urandom;
    memData   = d0;
    mem_delay = 2;
    reset     = 1'b1;
    step();
    chk("rmf_refetch_req", 32'(memReq), 32'd1);
    chk("rmf_refetch_addr", 32'(memAddr), 32'd4);
    step();
    step();
    chk("rmf_refetch_stall", 32'(stall), 32'd0);
    chk("rmf_refetch_instr", instruction, d0);
    step();

    // Randomized transactions against the buffer/latency model
    m_pc    = 32'd128;
    m_instr = d0;
    m_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] npc;
      logic [31:0] ndata;
      logic [31:0] exp_instr;
      int          d;
      int          r;
      int          exp_lat;
      int          exp_err;
      int          lat;
      int          errs;

      r = int'($urandom_range(0, 99));
      if (r < 25) npc = m_pc;
      else if (r < 45) npc = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(1, 31));
      else npc = $urandom & 32'hFFFF_FFE0;
      d     = int'($urandom_range(1, 18));
      ndata = $urandom;

      if (m_valid && npc == m_pc) begin
        exp_lat = 0; exp_instr = m_instr; exp_err = 0;
      end else if (npc[4:0] != 5'd0) begin
        exp_lat = 1; exp_instr = 32'd0; exp_err = 1;
      end else if (d <= int'(TMO)) begin
        exp_lat = d + 1; exp_instr = ndata; exp_err = 0;
      end else begin
        exp_lat = int'(TMO) + 1; exp_instr = 32'd0; exp_err = 1;
      end

      mem_delay = d;
      memData   = ndata;
      pc        = npc;
      #1;
      lat  = -1;
      errs = 0;
      for (int c = 0; c <= 40; c++) begin
        if (fetchErr) errs++;
        if (c == 1 && memReq) chk($sformatf("rnd%0d_addr", t), 32'(memAddr), npc >> 5);
        if (!stall) begin
          lat = c;
          break;
        end
        step();
      end
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_instr", t), instruction, exp_instr);
      chk($sformatf("rnd%0d_err", t), 32'(errs), 32'(exp_err));
      m_pc    = npc;
      m_instr = exp_instr;
      m_valid = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
